// File: rtl/spi_rx_byte.sv
// SPI mode-0 byte receiver: synchronizes the SPI pins into the system clock
// domain, assembles bytes and pushes each completed byte into a downstream FIFO.
module spi_rx_byte #(
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_sck,
    input  logic        i_cs_n,
    input  logic        i_mosi,
    input  logic        i_full,
    input  logic        i_clr_ovr,
    output logic        o_wr,
    output logic [7:0]  o_data,
    output logic        o_overrun,
    output logic        o_frame_err,
    output logic        o_busy,
    output logic [15:0] o_frame_bytes
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;

    state_t      state_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        wr_q;
    logic [7:0]  data_q;
    logic        overrun_q;
    logic        frame_err_q;
    logic        busy_q;
    logic [15:0] frame_bytes_q;

    logic        sck_s;
    logic        cs_s;
    logic        mosi_s;
    logic        sck_rise;
    logic [7:0]  shift_d;
    logic [2:0]  bit_cnt_d;
    logic [2:0]  bit_cnt_after;
    logic [15:0] frame_bytes_d;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;

    // Chip select resets to the deasserted level so reset never looks like a frame start.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], i_sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
            sck_prev_q  <= sck_s;
        end
    end

    always_comb begin
        shift_d       = (MSB_FIRST != 0) ? {shift_q[6:0], mosi_s} : {mosi_s, shift_q[7:1]};
        bit_cnt_d     = bit_cnt_q + 3'd1;
        bit_cnt_after = sck_rise ? bit_cnt_d : bit_cnt_q;
        frame_bytes_d = (frame_bytes_q == 16'hFFFF) ? frame_bytes_q : frame_bytes_q + 16'd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            wr_q          <= 1'b0;
            data_q        <= 8'h00;
            overrun_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_bytes_q <= 16'h0000;
        end else begin
            wr_q        <= 1'b0;
            frame_err_q <= 1'b0;
            if (i_clr_ovr) overrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!cs_s) begin
                        state_q       <= ACTIVE;
                        busy_q        <= 1'b1;
                        bit_cnt_q     <= 3'd0;
                        shift_q       <= 8'h00;
                        frame_bytes_q <= 16'h0000;
                    end
                end
                ACTIVE: begin
                    if (sck_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_d;
                        if (bit_cnt_q == 3'd7) begin
                            if (!i_full) begin
                                wr_q          <= 1'b1;
                                data_q        <= shift_d;
                                frame_bytes_q <= frame_bytes_d;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end
                    // A byte completing in the same cycle as CS release leaves the count at 0.
                    if (cs_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (bit_cnt_after != 3'd0) frame_err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_wr          = wr_q;
    assign o_data        = data_q;
    assign o_overrun     = overrun_q;
    assign o_frame_err   = frame_err_q;
    assign o_busy        = busy_q;
    assign o_frame_bytes = frame_bytes_q;

endmodule

// File: tb/tb_spi_rx_byte.sv
// Directed bench for spi_rx_byte: table of single-byte frames plus hand-written
// sequences for latency, multi-byte frames, CS/SCK coincidence and mid-byte reset.
module tb_spi_rx_byte;

    logic        clk = 1'b0;
    logic        rstN;
    logic        sck;
    logic        csN;
    logic        mosi;
    logic        full;
    logic        clrOvr;

    logic        wr;
    logic [7:0]  data;
    logic        overrun;
    logic        frameErr;
    logic        busy;
    logic [15:0] frameBytes;

    logic        lsbWr;
    logic [7:0]  lsbData;
    logic        lsbOverrun;
    logic        lsbFrameErr;
    logic        lsbBusy;
    logic [15:0] lsbFrameBytes;

    int checks   = 0;
    int failures = 0;

    int          wrCount    = 0;
    int          ferrCount  = 0;
    int          consecWr   = 0;
    logic        prevWr     = 1'b0;
    logic [7:0]  wrLog[$];

    always #5 clk = ~clk;

    spi_rx_byte #(.SYNC_STAGES(2), .MSB_FIRST(1)) dut (
        .i_clk(clk), .i_reset(rstN), .i_sck(sck), .i_cs_n(csN), .i_mosi(mosi),
        .i_full(full), .i_clr_ovr(clrOvr),
        .o_wr(wr), .o_data(data), .o_overrun(overrun), .o_frame_err(frameErr),
        .o_busy(busy), .o_frame_bytes(frameBytes)
    );

    spi_rx_byte #(.SYNC_STAGES(2), .MSB_FIRST(0)) dutLsb (
        .i_clk(clk), .i_reset(rstN), .i_sck(sck), .i_cs_n(csN), .i_mosi(mosi),
        .i_full(full), .i_clr_ovr(clrOvr),
        .o_wr(lsbWr), .o_data(lsbData), .o_overrun(lsbOverrun), .o_frame_err(lsbFrameErr),
        .o_busy(lsbBusy), .o_frame_bytes(lsbFrameBytes)
    );

    // Record every write strobe and frame-error cycle seen by the MSB-first receiver.
    always @(negedge clk) begin
        if (wr) begin
            wrCount = wrCount + 1;
            wrLog.push_back(data);
            if (prevWr) consecWr = consecWr + 1;
        end
        if (frameErr) ferrCount = ferrCount + 1;
        prevWr = wr;
    end

    typedef struct {
        logic [7:0]  tx;
        int          nBits;
        logic        full;
        int          expWr;
        logic [7:0]  expData;
        logic [7:0]  expLsb;
        logic        expOvr;
        int          expFerr;
        logic [15:0] expFb;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBit(input logic b);
        mosi = b;
        waitClk(4);
        sck = 1'b1;
        waitClk(4);
        sck = 1'b0;
    endtask

    task automatic sendBits(input logic [7:0] tx, input int n);
        for (int i = 0; i < n; i++) sendBit(tx[7-i]);
    endtask

    task automatic applyStimulus(input logic [7:0] tx, input int nBits, input logic fullIn);
        full = fullIn;
        csN  = 1'b0;
        waitClk(6);
        sendBits(tx, nBits);
        waitClk(4);
        csN = 1'b1;
        waitClk(8);
        full = 1'b0;
    endtask

    task automatic pulseClr();
        clrOvr = 1'b1;
        waitClk(1);
        clrOvr = 1'b0;
        waitClk(1);
    endtask

    initial begin
        int wrBase;
        int ferrBase;
        int logBase;
        int latency;

        vecs[0] = '{8'hA5, 8, 1'b0, 1, 8'hA5, 8'hA5, 1'b0, 0, 16'd1};
        vecs[1] = '{8'h55, 8, 1'b1, 0, 8'hA5, 8'hA5, 1'b1, 0, 16'd0};
        vecs[2] = '{8'hFF, 5, 1'b0, 0, 8'hA5, 8'hA5, 1'b0, 1, 16'd0};
        vecs[3] = '{8'h81, 8, 1'b0, 1, 8'h81, 8'h81, 1'b0, 0, 16'd1};
        vecs[4] = '{8'h80, 8, 1'b0, 1, 8'h80, 8'h01, 1'b0, 0, 16'd1};
        vecs[5] = '{8'h12, 8, 1'b0, 1, 8'h12, 8'h48, 1'b0, 0, 16'd1};
        vecs[6] = '{8'h00, 8, 1'b0, 1, 8'h00, 8'h00, 1'b0, 0, 16'd1};
        vecs[7] = '{8'h0F, 1, 1'b0, 0, 8'h00, 8'h00, 1'b0, 1, 16'd0};

        rstN   = 1'b0;
        sck    = 1'b0;
        csN    = 1'b1;
        mosi   = 1'b0;
        full   = 1'b0;
        clrOvr = 1'b0;
        waitClk(3);
        checkOutput("reset_wr", {31'd0, wr}, 32'd0);
        checkOutput("reset_data", {24'd0, data}, 32'h00);
        checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("reset_frame_err", {31'd0, frameErr}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_frame_bytes", {16'd0, frameBytes}, 32'd0);
        rstN = 1'b1;
        waitClk(4);

        for (int v = 0; v < 8; v++) begin
            wrBase   = wrCount;
            ferrBase = ferrCount;
            applyStimulus(vecs[v].tx, vecs[v].nBits, vecs[v].full);
            checkOutput($sformatf("v%0d_wr_count", v), wrCount - wrBase, vecs[v].expWr);
            checkOutput($sformatf("v%0d_data", v), {24'd0, data}, {24'd0, vecs[v].expData});
            checkOutput($sformatf("v%0d_lsb_data", v), {24'd0, lsbData}, {24'd0, vecs[v].expLsb});
            checkOutput($sformatf("v%0d_overrun", v), {31'd0, overrun}, {31'd0, vecs[v].expOvr});
            checkOutput($sformatf("v%0d_frame_err_cycles", v), ferrCount - ferrBase, vecs[v].expFerr);
            checkOutput($sformatf("v%0d_frame_bytes", v), {16'd0, frameBytes}, {16'd0, vecs[v].expFb});
            checkOutput($sformatf("v%0d_busy_after", v), {31'd0, busy}, 32'd0);
            pulseClr();
            checkOutput($sformatf("v%0d_overrun_cleared", v), {31'd0, overrun}, 32'd0);
        end

        // Two bytes in one frame.
        wrBase   = wrCount;
        ferrBase = ferrCount;
        logBase  = wrLog.size();
        csN = 1'b0;
        waitClk(6);
        checkOutput("two_byte_busy_active", {31'd0, busy}, 32'd1);
        sendBits(8'h3C, 8);
        sendBits(8'hC3, 8);
        waitClk(4);
        checkOutput("two_byte_frame_bytes_live", {16'd0, frameBytes}, 32'd2);
        csN = 1'b1;
        waitClk(8);
        checkOutput("two_byte_wr_count", wrCount - wrBase, 32'd2);
        if (wrLog.size() >= logBase + 2) begin
            checkOutput("two_byte_first", {24'd0, wrLog[logBase]}, 32'h3C);
            checkOutput("two_byte_second", {24'd0, wrLog[logBase+1]}, 32'hC3);
        end else begin
            checkOutput("two_byte_log_size", wrLog.size() - logBase, 32'd2);
        end
        checkOutput("two_byte_frame_bytes", {16'd0, frameBytes}, 32'd2);
        checkOutput("two_byte_frame_err", ferrCount - ferrBase, 32'd0);

        // Latency of o_wr from the edge that first samples the 8th SCK rise.
        latency = 0;
        csN = 1'b0;
        waitClk(6);
        sendBits(8'hA5, 7);
        mosi = 1'b1;
        waitClk(4);
        sck = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (wr && latency == 0) latency = k;
        end
        @(negedge clk);
        sck = 1'b0;
        waitClk(4);
        csN = 1'b1;
        waitClk(8);
        checkOutput("latency_edges", latency, 32'd3);
        checkOutput("latency_data", {24'd0, data}, 32'hA5);

        // Final SCK rise and CS release arrive in the same cycle.
        wrBase   = wrCount;
        ferrBase = ferrCount;
        csN = 1'b0;
        waitClk(6);
        sendBits(8'h6B, 7);
        mosi = 1'b1;
        waitClk(4);
        sck = 1'b1;
        csN = 1'b1;
        waitClk(4);
        sck = 1'b0;
        waitClk(8);
        checkOutput("coincide_wr_count", wrCount - wrBase, 32'd1);
        checkOutput("coincide_data", {24'd0, data}, 32'h6B);
        checkOutput("coincide_lsb_data", {24'd0, lsbData}, 32'hD6);
        checkOutput("coincide_frame_err", ferrCount - ferrBase, 32'd0);
        checkOutput("coincide_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a byte while CS stays low.
        wrBase   = wrCount;
        ferrBase = ferrCount;
        csN = 1'b0;
        waitClk(6);
        sendBits(8'hFF, 3);
        rstN = 1'b0;
        waitClk(2);
        checkOutput("midrst_wr", {31'd0, wr}, 32'd0);
        checkOutput("midrst_data", {24'd0, data}, 32'h00);
        checkOutput("midrst_overrun", {31'd0, overrun}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_frame_bytes", {16'd0, frameBytes}, 32'd0);
        rstN = 1'b1;
        waitClk(2);
        sendBits(8'h0F, 8);
        waitClk(4);
        csN = 1'b1;
        waitClk(8);
        checkOutput("midrst_wr_count", wrCount - wrBase, 32'd1);
        checkOutput("midrst_new_data", {24'd0, data}, 32'h0F);
        checkOutput("midrst_new_frame_bytes", {16'd0, frameBytes}, 32'd1);
        checkOutput("midrst_frame_err", ferrCount - ferrBase, 32'd0);

        checkOutput("no_back_to_back_wr", consecWr, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
